// File: rtl/booth_csa_feeder.sv
// booth_csa_feeder: iterative signed 32x32 radix-4 Booth multiplier front end.
// Accumulates the 64-bit product as a carry-save pair (S, C), one Booth digit
// per cycle over 16 cycles, then presents prop/gen/cin for product columns
// [63:26] to the downstream CARRY4 carry chain.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand pair valid          in_ready   block can accept operands
//   a, b       signed 32-bit operands
//   out_valid  prop/gen/cin valid          out_ready  carry chain accepts
//   prop       S ^ C, columns [63:26]      gen        S, columns [63:26]
//   cin        carry into column 26        busy       high in ACC or HOLD
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// ACC   | one Booth digit per cycle, digits 0..15
// HOLD  | prop/gen/cin valid, held until out_ready
module booth_csa_feeder #(
  parameter int EXACT_CIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [37:0] prop,
  output logic [37:0] gen,
  output logic        cin,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_s;
  logic [63:0] r_c;
  logic [3:0]  r_i;
  logic [37:0] r_prop;
  logic [37:0] r_gen;
  logic        r_cin;
  logic        r_in_ready;

  logic        w_accept;
  logic        w_last;
  logic [32:0] w_bx;
  logic [5:0]  w_shamt;
  logic [2:0]  w_dig;
  logic [63:0] w_a64;
  logic [63:0] w_mult;
  logic [63:0] w_p;
  logic [63:0] w_s_nxt;
  logic [63:0] w_c_nxt;
  logic        w_cin_exact;
  logic        w_cin_approx;
  logic        w_cin;

  assign w_accept = in_valid && r_in_ready && (r_state == ST_IDLE);
  assign w_last   = (r_i == 4'd15);

  // b[-1] = 0 is supplied by the appended zero, so digit i sits at bits 2i+2..2i.
  assign w_bx    = {r_b, 1'b0};
  assign w_shamt = {1'b0, r_i, 1'b0};
  assign w_dig   = w_bx[w_shamt +: 3];
  assign w_a64   = {{32{r_a[31]}}, r_a};

  always_comb begin
    w_mult = 64'd0;
    case (w_dig)
      3'b001, 3'b010: w_mult = w_a64;
      3'b011:         w_mult = w_a64 << 1;
      3'b100:         w_mult = ~(w_a64 << 1) + 64'd1;
      3'b101, 3'b110: w_mult = ~w_a64 + 64'd1;
      default:        w_mult = 64'd0;
    endcase
  end

  assign w_p     = w_mult << w_shamt;
  assign w_s_nxt = r_s ^ r_c ^ w_p;
  assign w_c_nxt = ((r_s & r_c) | (r_s & w_p) | (r_c & w_p)) << 1;

  // Exact carry out of the low 26 columns vs. the cheap single-column estimate.
  assign w_cin_exact  = |(({1'b0, w_s_nxt[25:0]} + {1'b0, w_c_nxt[25:0]}) >> 26);
  assign w_cin_approx = w_s_nxt[25] & w_c_nxt[25];
  assign w_cin        = (EXACT_CIN != 0) ? w_cin_exact : w_cin_approx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_ACC;
      ST_ACC:  if (w_last)    w_state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_s        <= 64'd0;
      r_c        <= 64'd0;
      r_i        <= 4'd0;
      r_prop     <= 38'd0;
      r_gen      <= 38'd0;
      r_cin      <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      // in_ready is registered so it rises on the first edge after reset release.
      r_in_ready <= (w_state_nxt == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a <= a;
            r_b <= b;
            r_s <= 64'd0;
            r_c <= 64'd0;
            r_i <= 4'd0;
          end
        end
        ST_ACC: begin
          r_s <= w_s_nxt;
          r_c <= w_c_nxt;
          if (w_last) begin
            r_prop <= w_s_nxt[63:26] ^ w_c_nxt[63:26];
            r_gen  <= w_s_nxt[63:26];
            r_cin  <= w_cin;
          end else begin
            r_i <= r_i + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == ST_HOLD);
  assign busy      = (r_state == ST_ACC) || (r_state == ST_HOLD);
  assign prop      = r_prop;
  assign gen       = r_gen;
  assign cin       = r_cin;

endmodule

// File: doc/booth_csa_feeder.md
Name: booth_csa_feeder

Overview:
- Iterative signed 32x32 radix-4 Booth multiplier front end. Builds the product as a 64-bit carry-save pair (S, C) over 16 cycles.
- Presents prop/gen/cin for columns [63:26] to the CARRY4-based upper-product carry chain, which resolves product[63:26].
- Sits between the operand source and the carry chain, with valid/ready handshakes on both sides.

Parameters:
- EXACT_CIN, 1: 1 = cin is the exact carry out of S[25:0]+C[25:0]; 0 = approximate cin = S[25] & C[25] (FABM truncation mode).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  32  signed multiplicand
- b  input  32  signed multiplier
- out_valid  output  1  prop/gen/cin valid
- out_ready  input  1  downstream carry chain stage accepts
- prop  output  38  bits [63:26]: S ^ C, carry-MUX select
- gen  output  38  bits [63:26]: S, carry-MUX data in
- cin  output  1  carry into column 26
- busy  output  1  high in ACC or HOLD

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset (asserted at any time, including mid-ACC or HOLD):
  - state = IDLE; S, C, digit counter, prop, gen, cin and out_valid all go to 0.
  - in_ready = 1 from the first clock edge after deassertion.
  - Any in-flight operation is discarded.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid & in_ready, latch a and b, clear S and C, set digit i=0, go to ACC.
  - ACC: in_ready=0, exactly 16 cycles, one Booth digit per cycle, i = 0..15.
    - Digit i = {b[2i+1], b[2i], b[2i-1]}, with b[-1] = 0.
    - Multiple M in {0, +A, +2A, -A, -2A}, where A = a sign-extended to 64 bits.
    - Negation is exact two's complement. P = M << 2i, mod 2^64.
    - 3:2 compression: S' = S ^ C ^ P; C' = ((S&C) | (S&P) | (C&P)) << 1, truncated to 64 bits.
    - After digit 15, register prop = S'[63:26] ^ C'[63:26], gen = S'[63:26] and cin (per EXACT_CIN, from S'/C'). Set out_valid=1 and go to HOLD.
  - HOLD: out_valid=1; prop, gen and cin are held stable while out_ready=0. On out_ready=1, out_valid drops next edge and the block returns to IDLE.
- Latency: operands accepted on edge T; out_valid high from edge T+16. Throughput is one product per 17 cycles minimum, because HOLD cannot overlap IDLE.
- Invariant (every completed operation): S + C ≡ a*b (mod 2^64), as signed 64-bit.
  - EXACT_CIN=1: the chain result equals (a*b)[63:26] exactly.
  - EXACT_CIN=0: the result may be low by 2^26 only when the true carry differs from S[25]&C[25].
- Boundary conditions:
  - in_valid is ignored outside IDLE.
  - a and b may change after acceptance without effect.
  - out_ready is ignored when out_valid=0.
  - The counter wraps never; it is exited at 15.
- No combinational path from in_valid or out_ready to any output except through state registers.

Test Plan:
- a=0x7FFFFFFF, b=0x7FFFFFFF, EXACT_CIN=1 -> out_valid at T+16; chain(prop,gen,cin) = 0x3FFFFFFF00000001>>26 = 0x0FFFFFFFC0 (38 bits).
- a=0x80000000, b=0x80000000 -> product 2^62; chain result = 2^36. Then a=0xFFFFFFFF, b=0xFFFFFFFF -> product 1, chain result 0, cin=0.
- a=0x80000000, b=0x00000001 -> product -2^31; chain result = 38'h3FFFFFFFE0 (sign-filled).
- Backpressure: out_ready=0 for 10 cycles after out_valid -> prop/gen/cin and out_valid constant, in_ready=0, in_valid pulses ignored. On out_ready=1, IDLE on the next edge, then accept a new pair.
- Reset at ACC cycle 7 -> all outputs 0 immediately (asynchronous). After release, a=3, b=-5 completes with chain result = (-15)>>26 = all ones.
- EXACT_CIN=0, 10k random pairs -> result equals exact, or exact minus 1 (in units of 2^26). Any other value is a failure; log the mismatch rate.
